// File: rtl/cell4_exerciser_if.sv
// Control/CUT bundle for the 4-input cell exerciser.
//   start      : run request from the control block
//   truth      : expected cell output per vector, truth[v] for {i3,i2,i1,i0}=v
//   q_cut      : output of the cell under test
//   i0..i3     : cell-under-test inputs
//   busy, done : run status; done holds until the next accepted start
//   pass       : done with no mismatches
//   err_cnt    : saturating mismatch count
//   first_fail : vector index of the first mismatch (0 if none)
// slave  : exerciser side
// master : control block / CUT side
interface cell4_exerciser_if #(
  parameter int unsigned ERR_W = 5
);
  logic             start;
  logic [15:0]      truth;
  logic             q_cut;
  logic             i0;
  logic             i1;
  logic             i2;
  logic             i3;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;
  logic [3:0]       first_fail;

  modport slave (
    input  start, truth, q_cut,
    output i0, i1, i2, i3, busy, done, pass, err_cnt, first_fail
  );

  modport master (
    output start, truth, q_cut,
    input  i0, i1, i2, i3, busy, done, pass, err_cnt, first_fail
  );
endinterface

// File: rtl/cell4_exerciser.sv
// On-chip exerciser for 4-input/1-output library cells. Walks all 16 input
// vectors into the cell under test, waits SETTLE cycles after each drive,
// samples q_cut against a truth table latched at start, and reports
// pass / saturating mismatch count / first failing vector.
// Ports:
//   ck    : clock, rising edge
//   nrst  : asynchronous active-low reset
//   bus   : cell4_exerciser_if.slave (start, truth, q_cut in; CUT inputs
//           and result outputs out). All outputs are registered.
// Parameters:
//   SETTLE : cycles between driving a vector and sampling q_cut (1..15)
//   ERR_W  : err_cnt width, must match the interface ERR_W
module cell4_exerciser #(
  parameter int unsigned SETTLE = 2,
  parameter int unsigned ERR_W  = 5
) (
  input logic               ck,
  input logic               nrst,
  cell4_exerciser_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  state_t           state, state_n;
  logic [3:0]       vec, vec_n;
  logic [3:0]       timer, timer_n;
  logic [3:0]       cut_in, cut_in_n;
  logic [15:0]      truth_l, truth_l_n;
  logic [ERR_W-1:0] err, err_n;
  logic [3:0]       first, first_n;
  logic             busy, busy_n;
  logic             done, done_n;
  logic             pass, pass_n;
  logic             mism;

  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      state   <= ST_IDLE;
      vec     <= '0;
      timer   <= '0;
      cut_in  <= '0;
      truth_l <= '0;
      err     <= '0;
      first   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
    end else begin
      state   <= state_n;
      vec     <= vec_n;
      timer   <= timer_n;
      cut_in  <= cut_in_n;
      truth_l <= truth_l_n;
      err     <= err_n;
      first   <= first_n;
      busy    <= busy_n;
      done    <= done_n;
      pass    <= pass_n;
    end
  end

  assign mism = (bus.q_cut != truth_l[vec]);

  always_comb begin
    state_n   = state;
    vec_n     = vec;
    timer_n   = timer;
    cut_in_n  = cut_in;
    truth_l_n = truth_l;
    err_n     = err;
    first_n   = first;
    busy_n    = busy;
    done_n    = done;
    pass_n    = pass;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_n   = ST_DRIVE;
          vec_n     = '0;
          truth_l_n = bus.truth;
          err_n     = '0;
          first_n   = '0;
          busy_n    = 1'b1;
          done_n    = 1'b0;
          pass_n    = 1'b0;
        end
      end
      ST_DRIVE: begin
        cut_in_n = vec;
        timer_n  = 4'(SETTLE - 1);
        state_n  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (timer == '0) state_n = ST_SAMPLE;
        else             timer_n = timer - 4'd1;
      end
      ST_SAMPLE: begin
        if (mism) begin
          if (err != '1) err_n = err + 1'b1;
          // err stays nonzero once any mismatch is seen (saturation never
          // wraps), so err==0 identifies the first mismatch of the run.
          if (err == '0) first_n = vec;
        end
        if (vec == 4'd15) begin
          state_n = ST_DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          pass_n  = !mism && (err == '0);
        end else begin
          vec_n   = vec + 4'd1;
          state_n = ST_DRIVE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign bus.i0         = cut_in[0];
  assign bus.i1         = cut_in[1];
  assign bus.i2         = cut_in[2];
  assign bus.i3         = cut_in[3];
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.pass       = pass;
  assign bus.err_cnt    = err;
  assign bus.first_fail = first;

endmodule

// File: tb/tb_cell4_exerciser.sv
// Bench for cell4_exerciser: two instances (ERR_W=5 and ERR_W=3) run in
// lockstep against a behavioural cell model with a configurable output delay.
module tb_cell4_exerciser;
  localparam int unsigned S = 2;
  localparam int RUN = 16 * (S + 2);

  logic ck = 1'b0;
  logic nrst = 1'b0;
  logic start = 1'b0;
  logic [15:0] truth = '0;
  logic [15:0] cut_tt = '0;
  int dly = 0;
  logic [3:0] held_vec = '0;
  int checks = 0;
  int errors = 0;

  always #5 ck = ~ck;

  cell4_exerciser_if #(.ERR_W(5)) bus5 ();
  cell4_exerciser_if #(.ERR_W(3)) bus3 ();

  cell4_exerciser #(.SETTLE(S), .ERR_W(5)) dut  (.ck(ck), .nrst(nrst), .bus(bus5.slave));
  cell4_exerciser #(.SETTLE(S), .ERR_W(3)) dut3 (.ck(ck), .nrst(nrst), .bus(bus3.slave));

  logic [3:0] vec5, vec3;
  logic [7:0] hist5 = '0;
  logic [7:0] hist3 = '0;
  assign vec5 = {bus5.i3, bus5.i2, bus5.i1, bus5.i0};
  assign vec3 = {bus3.i3, bus3.i2, bus3.i1, bus3.i0};

  // Cell model: combinational truth table cut_tt, output delayed by dly cycles.
  always @(posedge ck) begin
    hist5 <= {hist5[6:0], cut_tt[vec5]};
    hist3 <= {hist3[6:0], cut_tt[vec3]};
  end
  assign bus5.start = start;
  assign bus3.start = start;
  assign bus5.truth = truth;
  assign bus3.truth = truth;
  assign bus5.q_cut = (dly == 0) ? cut_tt[vec5] : hist5[dly-1];
  assign bus3.q_cut = (dly == 0) ? cut_tt[vec3] : hist3[dly-1];

  // Reference: a cell whose output lags by more than the settle window
  // presents the previous vector's response at sampling time.
  function automatic void model(input logic [15:0] tt, input logic [15:0] cut, input int k,
                                input logic [3:0] prev, output int cnt, output logic [3:0] ff);
    logic [3:0] src;
    cnt = 0;
    ff = '0;
    for (int v = 0; v < 16; v++) begin
      if (k <= int'(S)) src = 4'(v);
      else              src = (v == 0) ? prev : 4'(v - 1);
      if (cut[src] != tt[v]) begin
        if (cnt == 0) ff = 4'(v);
        cnt++;
      end
    end
  endfunction

  function automatic int sat(input int c, input int w);
    return (c > (1 << w) - 1) ? (1 << w) - 1 : c;
  endfunction

  task automatic run_once(output int n);
    @(negedge ck);
    start = 1'b1;
    @(posedge ck);
    #1 start = 1'b0;
    n = 0;
    while (bus5.done !== 1'b1 && n < 400) begin
      @(posedge ck);
      #1 n++;
    end
    held_vec = 4'd15;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (12) @(posedge ck);
    #1;
    checks++;
    if ({bus5.busy, bus5.done, bus5.pass, bus5.err_cnt, bus5.first_fail, vec5} !== '0 ||
        {bus3.busy, bus3.done, bus3.pass, bus3.err_cnt, bus3.first_fail, vec3} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b pass=%b err=%0d ff=%0d vec=%0d want all 0",
               bus5.busy, bus5.done, bus5.pass, bus5.err_cnt, bus5.first_fail, vec5);
    end
    @(negedge ck) nrst = 1'b1;
    held_vec = '0;
  endtask

  task automatic test_scenario(input string name, input logic [15:0] tt, input logic [15:0] cut, input int k);
    int n, cnt;
    logic [3:0] ff;
    truth = tt;
    cut_tt = cut;
    dly = k;
    model(tt, cut, k, held_vec, cnt, ff);
    run_once(n);
    checks++;
    if (n != RUN) begin
      errors++; $display("FAIL %s run_length: got %0d want %0d", name, n, RUN);
    end
    checks++;
    if (bus5.err_cnt !== 5'(sat(cnt, 5)) || bus3.err_cnt !== 3'(sat(cnt, 3))) begin
      errors++;
      $display("FAIL %s err_cnt: got %0d/%0d want %0d/%0d", name, bus5.err_cnt, bus3.err_cnt, sat(cnt, 5), sat(cnt, 3));
    end
    checks++;
    if (bus5.first_fail !== ff || bus3.first_fail !== ff) begin
      errors++; $display("FAIL %s first_fail: got %0d/%0d want %0d", name, bus5.first_fail, bus3.first_fail, ff);
    end
    checks++;
    if (bus5.pass !== (cnt == 0) || bus3.pass !== (cnt == 0) || bus5.busy !== 1'b0 || vec5 !== 4'd15) begin
      errors++;
      $display("FAIL %s status: got pass=%b busy=%b vec=%0d want pass=%b busy=0 vec=15", name, bus5.pass, bus5.busy, vec5, cnt == 0);
    end
  endtask

  task automatic test_golden();
    test_scenario("and4_golden", 16'h8000, 16'h8000, 0);
    test_scenario("stuck0", 16'h8000, 16'h0000, 0);
    test_scenario("stuck1", 16'h8000, 16'hFFFF, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      logic [15:0] tt, mask;
      tt = 16'($urandom);
      mask = 16'($urandom) & 16'($urandom) & 16'($urandom);
      test_scenario("random", tt, tt ^ mask, int'($urandom_range(0, S)));
    end
  endtask

  task automatic test_timing();
    logic [15:0] tt;
    tt = 16'($urandom);
    test_scenario("delay_settle", tt, tt, int'(S));
    test_scenario("delay_settle_plus1", tt, tt, int'(S) + 1);
    test_scenario("delay_settle_plus1_nand4", 16'h7FFF, 16'h7FFF, int'(S) + 1);
  endtask

  task automatic test_control();
    int n, cnt;
    logic [3:0] ff;
    logic [15:0] tt;
    tt = 16'($urandom);
    truth = tt;
    cut_tt = tt ^ 16'h0410;
    dly = 0;
    model(tt, cut_tt, 0, held_vec, cnt, ff);
    @(negedge ck) start = 1'b1;
    @(posedge ck);
    #1 start = 1'b0;
    n = 0;
    while (bus5.done !== 1'b1 && n < 400) begin
      @(posedge ck);
      #1 n++;
      if (n == 20) begin start = 1'b1; truth = ~tt; end
      if (n == 21) start = 1'b0;
    end
    held_vec = 4'd15;
    checks++;
    if (n != RUN) begin errors++; $display("FAIL busy_start run_length: got %0d want %0d", n, RUN); end
    checks++;
    if (bus5.err_cnt !== 5'(cnt) || bus5.first_fail !== ff) begin
      errors++; $display("FAIL latched_truth: got err=%0d ff=%0d want err=%0d ff=%0d", bus5.err_cnt, bus5.first_fail, cnt, ff);
    end
    // Loop mode: start held through DONE restarts the run on the next edge.
    truth = tt;
    @(negedge ck) start = 1'b1;
    @(posedge ck);
    #1;
    n = 0;
    while (bus5.done !== 1'b1 && n < 400) begin
      @(posedge ck);
      #1 n++;
    end
    checks++;
    if (n != RUN || bus5.err_cnt !== 5'(cnt)) begin
      errors++; $display("FAIL loop_first: got len=%0d err=%0d want len=%0d err=%0d", n, bus5.err_cnt, RUN, cnt);
    end
    @(posedge ck);
    #1;
    checks++;
    if (bus5.busy !== 1'b1 || bus5.done !== 1'b0 || bus5.err_cnt !== '0) begin
      errors++; $display("FAIL loop_restart: got busy=%b done=%b err=%0d want busy=1 done=0 err=0", bus5.busy, bus5.done, bus5.err_cnt);
    end
    start = 1'b0;
    n = 0;
    while (bus5.done !== 1'b1 && n < 400) begin
      @(posedge ck);
      #1 n++;
    end
    checks++;
    if (n != RUN || bus5.err_cnt !== 5'(cnt) || bus5.first_fail !== ff) begin
      errors++; $display("FAIL loop_second: got len=%0d err=%0d ff=%0d want len=%0d err=%0d ff=%0d",
                         n, bus5.err_cnt, bus5.first_fail, RUN, cnt, ff);
    end
  endtask

  task automatic test_reset_midrun();
    int n;
    truth = 16'h8000;
    cut_tt = 16'hFFFF;
    dly = 0;
    @(negedge ck) start = 1'b1;
    @(posedge ck);
    #1 start = 1'b0;
    for (n = 0; n < 1 + 7 * (int'(S) + 2); n++) @(posedge ck);
    #1;
    checks++;
    if (vec5 !== 4'd7 || bus5.busy !== 1'b1 || bus5.err_cnt !== 5'd7) begin
      errors++; $display("FAIL midrun_position: got vec=%0d busy=%b err=%0d want vec=7 busy=1 err=7", vec5, bus5.busy, bus5.err_cnt);
    end
    #2 nrst = 1'b0;
    #1;
    checks++;
    if ({bus5.busy, bus5.done, bus5.pass, bus5.err_cnt, bus5.first_fail, vec5} !== '0 ||
        {bus3.busy, bus3.done, bus3.pass, bus3.err_cnt, bus3.first_fail, vec3} !== '0) begin
      errors++; $display("FAIL async_reset: got busy=%b done=%b err=%0d vec=%0d want all 0", bus5.busy, bus5.done, bus5.err_cnt, vec5);
    end
    repeat (3) @(posedge ck);
    #1;
    checks++;
    if (bus5.done !== 1'b0) begin errors++; $display("FAIL reset_no_done: got %b want 0", bus5.done); end
    @(negedge ck) nrst = 1'b1;
    held_vec = '0;
    test_scenario("after_reset", 16'h8000, 16'h8000, 0);
  endtask

  initial begin
    test_reset();
    test_golden();
    test_random();
    test_timing();
    test_control();
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
